// File: rtl/kernel_host_if.sv
// Signal bundle between kernel_host, the command path and one kernel instance.
// master: the host side; slave: the surrounding system and kernel.
interface kernel_host_if;
  localparam int unsigned DATA_W = 64;

  logic              arg_valid;
  logic              arg_ready;
  logic [DATA_W-1:0] arg_data;
  logic              arg_ctrl;

  logic              k_r_enable;
  logic [DATA_W-1:0] k_init_i;
  logic              k_ctrl;
  logic              k_w_enable;
  logic [DATA_W-1:0] k_result;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_timeout;
  logic              busy;

  modport master (
    input  arg_valid, arg_data, arg_ctrl, k_w_enable, k_result, res_ready,
    output arg_ready, k_r_enable, k_init_i, k_ctrl, res_valid, res_data, res_timeout, busy
  );

  modport slave (
    output arg_valid, arg_data, arg_ctrl, k_w_enable, k_result, res_ready,
    input  arg_ready, k_r_enable, k_init_i, k_ctrl, res_valid, res_data, res_timeout, busy
  );
endinterface

// File: rtl/kernel_host.sv
// Launches a single-argument kernel, waits for done or timeout, returns the result.
// Optional KERNEL_HOST_CYCLE_COUNT_EN adds res_cycles (WAIT cycles at completion).
module kernel_host #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  kernel_host_if.master  hif
`ifdef KERNEL_HOST_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] res_cycles
`endif
);

  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_hit;

  logic arg_ready_d;
  logic k_r_enable_d;
  logic busy_d;
  logic res_valid_d;
  logic arg_load;
  logic res_capture;
  logic res_done;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; kernel done is only looked at in WAIT, stale levels elsewhere are ignored
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (hif.arg_valid) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (hif.k_w_enable || timeout_hit) state_d = ST_HOLD;
      ST_HOLD:   if (hif.res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output/datapath control; handshake flags are decoded from the next state so they register cleanly
  always_comb begin
    arg_ready_d  = (state_d == ST_IDLE);
    k_r_enable_d = (state_d == ST_LAUNCH);
    busy_d       = (state_d != ST_IDLE);
    res_valid_d  = (state_d == ST_HOLD);
    arg_load     = 1'b0;
    res_capture  = 1'b0;
    res_done     = 1'b0;
    cnt_d        = cnt_q;
    unique case (state_q)
      ST_IDLE:   arg_load = hif.arg_valid;
      ST_LAUNCH: cnt_d = CNT_W'(1);
      ST_WAIT: begin
        // completion takes priority over a coincident timeout
        if (hif.k_w_enable) begin
          res_capture = 1'b1;
          res_done    = 1'b1;
        end else if (timeout_hit) begin
          res_capture = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, argument register and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hif.arg_ready   <= 1'b0;
      hif.k_r_enable  <= 1'b0;
      hif.busy        <= 1'b0;
      hif.res_valid   <= 1'b0;
      hif.k_init_i    <= '0;
      hif.k_ctrl      <= 1'b0;
      hif.res_data    <= '0;
      hif.res_timeout <= 1'b0;
      cnt_q           <= '0;
`ifdef KERNEL_HOST_CYCLE_COUNT_EN
      res_cycles      <= '0;
`endif
    end else begin
      hif.arg_ready  <= arg_ready_d;
      hif.k_r_enable <= k_r_enable_d;
      hif.busy       <= busy_d;
      hif.res_valid  <= res_valid_d;
      cnt_q          <= cnt_d;
      if (arg_load) begin
        hif.k_init_i <= hif.arg_data;
        hif.k_ctrl   <= hif.arg_ctrl;
      end
      if (res_capture) begin
        hif.res_data    <= res_done ? hif.k_result : DATA_W'(0);
        hif.res_timeout <= ~res_done;
`ifdef KERNEL_HOST_CYCLE_COUNT_EN
        res_cycles      <= cnt_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_kernel_host.sv
// Randomized bench for kernel_host: a kernel model plus a transaction-level host model,
// compared against the DUT on every cycle, with a few literal anchors.
`timescale 1ns/1ps
module tb_kernel_host;
  localparam int unsigned TIMEOUT = 10;
  localparam int unsigned CNT_W   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  kernel_host_if hif();
`ifdef KERNEL_HOST_CYCLE_COUNT_EN
  logic [CNT_W-1:0] res_cycles;
`endif

  kernel_host #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
`ifdef KERNEL_HOST_CYCLE_COUNT_EN
    , .res_cycles (res_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Kernel model: done level L cycles after the start pulse (L=0: never), result = init+1
  int unsigned lat = 1;
  int unsigned kcd = 0;
  always @(posedge clk) begin
    if (hif.k_r_enable) begin
      hif.k_w_enable <= (lat == 1);
      hif.k_result   <= (lat == 1) ? hif.k_init_i + 64'd1 : {$urandom, $urandom};
      kcd            <= (lat > 1) ? lat - 1 : 0;
    end else if (kcd != 0) begin
      if (kcd == 1) begin
        hif.k_w_enable <= 1'b1;
        hif.k_result   <= hif.k_init_i + 64'd1;
      end
      kcd <= kcd - 1;
    end
  end

  // Host model: one transaction in flight, described by accept edge and kernel latency
  function automatic int unsigned eff_lat(input int unsigned l);
    return (l != 0 && l <= TIMEOUT) ? l : TIMEOUT;
  endfunction

  function automatic logic completes(input int unsigned l);
    return (l != 0 && l <= TIMEOUT);
  endfunction

  int unsigned cyc   = 0;
  int unsigned m_n   = 0;
  int unsigned m_lat = 0;
  logic        m_busy = 1'b0;
  logic [63:0] m_arg  = '0;
  logic        m_ctrl = 1'b0;

  function automatic logic exp_rv();
    return m_busy && (cyc >= m_n + eff_lat(m_lat) + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_arg  <= '0;
      m_ctrl <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if (exp_rv() && hif.res_ready) m_busy <= 1'b0;
      end else if (hif.arg_valid) begin
        m_busy <= 1'b1;
        m_n    <= cyc + 1;
        m_lat  <= lat;
        m_arg  <= hif.arg_data;
        m_ctrl <= hif.arg_ctrl;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_arg_ready", hif.arg_ready, 0);
      chk("rst_k_r_enable", hif.k_r_enable, 0);
      chk("rst_k_init_i", hif.k_init_i, 0);
      chk("rst_k_ctrl", hif.k_ctrl, 0);
      chk("rst_res_valid", hif.res_valid, 0);
      chk("rst_res_data", hif.res_data, 0);
      chk("rst_res_timeout", hif.res_timeout, 0);
      chk("rst_busy", hif.busy, 0);
`ifdef KERNEL_HOST_CYCLE_COUNT_EN
      chk("rst_res_cycles", 64'(res_cycles), 0);
`endif
    end else begin
      chk("arg_ready", hif.arg_ready, !m_busy);
      chk("busy", hif.busy, m_busy);
      chk("k_r_enable", hif.k_r_enable, m_busy && (cyc == m_n));
      chk("k_init_i", hif.k_init_i, m_arg);
      chk("k_ctrl", hif.k_ctrl, m_ctrl);
      chk("res_valid", hif.res_valid, exp_rv());
      if (exp_rv()) begin
        chk("res_data", hif.res_data, completes(m_lat) ? m_arg + 64'd1 : 64'd0);
        chk("res_timeout", hif.res_timeout, !completes(m_lat));
`ifdef KERNEL_HOST_CYCLE_COUNT_EN
        chk("res_cycles", 64'(res_cycles), 64'(eff_lat(m_lat)));
`endif
      end
    end
  end

  // One full transaction; returns the captured result and accept-to-valid cycle count
  task automatic run_txn(input logic [63:0] a, input logic c, input int unsigned l,
                         input int unsigned hold, input logic poke,
                         output logic [63:0] d, output logic to, output int unsigned lc,
                         output int unsigned rc);
    logic found;
    lat = l;
    @(negedge clk);
    hif.arg_valid = 1'b1;
    hif.arg_data  = a;
    hif.arg_ctrl  = c;
    @(negedge clk);
    hif.arg_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) + 20; i++) begin
      if (hif.res_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("res_valid_seen", found, 1);
    lc = cyc + 1 - m_n;
    d  = hif.res_data;
    to = hif.res_timeout;
`ifdef KERNEL_HOST_CYCLE_COUNT_EN
    rc = int'(res_cycles);
`else
    rc = 0;
`endif
    for (int i = 0; i < int'(hold); i++) begin
      if (poke) begin
        hif.arg_valid = 1'b1;
        hif.arg_data  = {$urandom, $urandom};
        hif.arg_ctrl  = 1'($urandom);
      end
      @(negedge clk);
    end
    hif.arg_valid = 1'b0;
    hif.res_ready = 1'b1;
    @(negedge clk);
    hif.res_ready = 1'b0;
  endtask

  logic [63:0] d;
  logic        to;
  int unsigned lc, rc, rl;

  initial begin
    hif.arg_valid = 1'b0;
    hif.arg_data  = '0;
    hif.arg_ctrl  = 1'b0;
    hif.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 41 -> 42, kernel latency 6, res_valid in cycle accept+8
    run_txn(64'd41, 1'b0, 6, 0, 1'b0, d, to, lc, rc);
    chk("lit_41_data", d, 64'd42);
    chk("lit_41_timeout", to, 0);
    chk("lit_41_latency", 64'(lc), 64'd8);

    // previous done level still high when 5 arrives
    run_txn(64'd5, 1'b1, 4, 0, 1'b0, d, to, lc, rc);
    chk("lit_stale_data", d, 64'd6);
    chk("lit_stale_latency", 64'(lc), 64'd6);

    // kernel never finishes
    run_txn(64'd3, 1'b0, 0, 1, 1'b0, d, to, lc, rc);
    chk("lit_to_data", d, 64'd0);
    chk("lit_to_timeout", to, 1);
    chk("lit_to_latency", 64'(lc), 64'(TIMEOUT + 2));
`ifdef KERNEL_HOST_CYCLE_COUNT_EN
    chk("lit_to_cycles", 64'(rc), 64'd10);
`endif
    run_txn(64'd100, 1'b0, 3, 0, 1'b0, d, to, lc, rc);
    chk("lit_after_to_data", d, 64'd101);

    // consumer stalls 20 cycles while new arguments are offered
    run_txn(64'd9, 1'b1, 2, 20, 1'b1, d, to, lc, rc);
    chk("lit_hold_data", d, 64'd10);

    // done exactly on the timeout cycle, then one cycle too late
    run_txn(64'd77, 1'b0, TIMEOUT, 0, 1'b0, d, to, lc, rc);
    chk("lit_edge_data", d, 64'd78);
    chk("lit_edge_timeout", to, 0);
`ifdef KERNEL_HOST_CYCLE_COUNT_EN
    chk("lit_edge_cycles", 64'(rc), 64'd10);
`endif
    run_txn(64'd78, 1'b0, TIMEOUT + 1, 0, 1'b0, d, to, lc, rc);
    chk("lit_late_timeout", to, 1);

    // reset while waiting on the kernel
    lat = 0;
    @(negedge clk);
    hif.arg_valid = 1'b1;
    hif.arg_data  = 64'h1234;
    hif.arg_ctrl  = 1'b1;
    @(negedge clk);
    hif.arg_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", hif.busy, 0);
    chk("async_rst_k_init_i", hif.k_init_i, 0);
    chk("async_rst_k_ctrl", hif.k_ctrl, 0);
    chk("async_rst_arg_ready", hif.arg_ready, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_txn(64'd7, 1'b0, 3, 0, 1'b0, d, to, lc, rc);
    chk("lit_post_rst_data", d, 64'd8);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      rl = $urandom_range(0, TIMEOUT + 3);
      run_txn({$urandom, $urandom}, 1'($urandom), rl, $urandom_range(0, 3), 1'($urandom),
              d, to, lc, rc);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kernel_host.md
# kernel_host

Host-side launcher for a synthesized single-argument kernel that uses the r_enable/init_i start, w_enable/result completion protocol. Accepts one 64-bit argument on a valid/ready input stream, pulses the kernel start for exactly one cycle, waits for completion with a cycle-count timeout, and presents the kernel result on a valid/ready output stream. Sits between the system command path and one kernel instance.

## Interface
- TIMEOUT, 1024: max cycles in WAIT before forced completion; legal 2..2^CNT_W-1
- CNT_W, 16: width of the wait-cycle counter
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- arg_valid  in  1  argument offered
- arg_ready  out  1  host can accept an argument
- arg_data  in  64  kernel argument
- arg_ctrl  in  1  value for kernel control input, latched with argument
- k_r_enable  out  1  one-cycle kernel start pulse
- k_init_i  out  64  argument to kernel
- k_ctrl  out  1  drives kernel controlArr
- k_w_enable  in  1  kernel done (level, held until next start)
- k_result  in  64  kernel result, valid while k_w_enable=1
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  64  captured result, 0 on timeout
- res_timeout  out  1  result produced by timeout
- busy  out  1  state != IDLE
- res_cycles  out  CNT_W  cycles spent in WAIT (only with KERNEL_HOST_CYCLE_COUNT_EN)

## Operation
- States: IDLE, LAUNCH, WAIT, HOLD.
- IDLE: arg_ready=1. On arg_valid: latch arg_data/arg_ctrl into argument register, go LAUNCH.
- LAUNCH: k_r_enable=1 for this cycle only; go WAIT; wait counter loaded with 1.
- WAIT: k_w_enable sampled every cycle. k_w_enable=1 -> res_data<=k_result, res_timeout<=0, go HOLD. Else if counter==TIMEOUT -> res_data<=0, res_timeout<=1, go HOLD. Else counter+1. Completion wins over timeout in the same cycle.
- HOLD: res_valid=1; res_data/res_timeout stable. On res_ready go IDLE.
- k_init_i and k_ctrl driven from the argument register at all times (stable through WAIT).
- k_w_enable in IDLE, LAUNCH, HOLD is ignored (stale level from the previous run is legal).
- Counter saturates, never wraps.
- Timeout does not abort the kernel; next LAUNCH restarts it via k_r_enable.

## Timing
- Reset values: arg_ready=0 during reset then 1 in IDLE; k_r_enable=0, k_init_i=0, k_ctrl=0, res_valid=0, res_data=0, res_timeout=0, busy=0, res_cycles=0, state IDLE.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values; pending result discarded.
- Arg accepted at edge N -> k_r_enable high in cycle N+1 -> WAIT from N+2.
- Kernel done level at cycle M (M >= N+2) -> res_valid high from M+1.
- Total latency accept-to-res_valid = kernel latency + 2 cycles.
- Result handshake at edge H -> arg_ready high in cycle H+1; one argument in flight, no overlap.
- arg_ready and res_valid never both high.

## Configuration
- KERNEL_HOST_CYCLE_COUNT_EN defined: res_cycles port present, captured with res_data = counter value at completion (TIMEOUT on timeout), held through HOLD, 0 in reset.
- Undefined: no res_cycles port, no extra registers; all other behaviour identical.

## Test plan
- Kernel model returns init+1, done 6 cycles after start; send arg 41 -> exactly one k_r_enable pulse, res_data=42, res_timeout=0, res_valid 8 cycles after accept.
- Model holds k_w_enable=1 from previous run when new arg 5 arrives -> stale level ignored, result taken only after model clears and reasserts.
- TIMEOUT=10, model never completes -> res_valid with res_data=0, res_timeout=1, res_cycles=10; next arg launches normally.
- res_ready held low 20 cycles in HOLD -> res_data stable, arg_ready=0, arg_valid ignored; release -> arg_ready next cycle.
- Done asserted on the exact TIMEOUT cycle -> res_timeout=0, real result returned.
- rst_n asserted during WAIT -> outputs at reset values asynchronously; after release, arg 7 completes with correct result.
